iter_normalize: RTL and testbench

- Multi-cycle, parametrised normaliser for the floating-point divider datapath.
- Accepts a wide unsigned quotient/remainder word and left-shifts it until the MSB is 1.
- Shifts up to STEP positions per cycle.
- Returns the fraction bits below the leading one, a two's-complement exponent adjustment, and zero/inexact flags.
- Valid/ready on both sides; a zero input terminates cleanly and never stalls.

---
 rtl/iter_normalize.sv | 160 ++++++++++++++++
 tb/tb_iter_normalize.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/iter_normalize.sv
// Multi-cycle left normaliser for the divider datapath: strips leading zeros STEP bits per cycle.
// Optional round-to-nearest-even on the final shift is enabled with `define NORM_ROUND_EN.
module iter_normalize #(
  parameter int IN_W       = 70,
  parameter int MAN_W      = 23,
  parameter int EXP_W      = 8,
  parameter int STEP       = 4,
  parameter int EXP_OFFSET = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp_adj,
  output logic             out_zero,
  output logic             out_inexact
);

  localparam int LW = $clog2(IN_W);
  localparam int ZW = $clog2(STEP + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  r_state;
  logic [IN_W-1:0]         r_word;
  logic [LW-1:0]           r_cnt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [MAN_W-1:0]        r_mant;
  logic [EXP_W-1:0]        r_exp;
  logic                    r_zero;
  logic                    r_inexact;

  logic [STEP-1:0]         w_win;
  logic [ZW-1:0]           w_z;
  logic [IN_W-1:0]         w_shift;
  logic [IN_W-1:0]         w_low;
  logic [LW-1:0]           w_cnt;
  logic                    w_final;
  logic [MAN_W-1:0]        w_mant;
  logic signed [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0]        w_mant_o;
  logic signed [EXP_W-1:0] w_exp_o;
  logic                    w_inexact;

  // Count of leading zeros in the window; STEP means the whole window is zero.
  function automatic logic [ZW-1:0] lz_win(input logic [STEP-1:0] win);
    logic [ZW-1:0] n;
    logic          found;
    n     = ZW'(STEP);
    found = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!found && win[i]) begin
        n     = ZW'(STEP - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

`ifdef NORM_ROUND_EN
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] m,
                                               input logic g, input logic s);
    logic up;
    up = g & (s | m[0]);
    return {1'b0, m} + {{MAN_W{1'b0}}, up};
  endfunction
`endif

  assign w_win     = r_word[IN_W-1 -: STEP];
  assign w_z       = lz_win(w_win);
  assign w_shift   = r_word << w_z;
  assign w_cnt     = r_cnt + LW'(w_z);
  assign w_final   = (w_z != ZW'(STEP));
  assign w_mant    = w_shift[IN_W-2 -: MAN_W];
  // Everything below the mantissa, left-aligned so the guard bit sits at the MSB.
  assign w_low     = w_shift << (MAN_W + 1);
  assign w_inexact = |w_low;
  assign w_exp     = EXP_W'(EXP_OFFSET) - EXP_W'(w_cnt);

`ifdef NORM_ROUND_EN
  logic [MAN_W:0] w_rnd;
  assign w_rnd    = round_rne(w_mant, w_low[IN_W-1], |w_low[IN_W-2:0]);
  assign w_mant_o = w_rnd[MAN_W-1:0];
  assign w_exp_o  = w_exp + EXP_W'(w_rnd[MAN_W]);
`else
  assign w_mant_o = w_mant;
  assign w_exp_o  = w_exp;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_zero      <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word     <= in_data;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (in_data == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_zero      <= 1'b1;
              r_mant      <= '0;
              r_exp       <= '0;
              r_inexact   <= 1'b0;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_word <= w_shift;
          r_cnt  <= w_cnt;
          if (w_final) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_mant      <= w_mant_o;
            r_exp       <= w_exp_o;
            r_inexact   <= w_inexact;
            r_zero      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_mant    = r_mant;
  assign out_exp_adj = r_exp;
  assign out_zero    = r_zero;
  assign out_inexact = r_inexact;

endmodule

// File: tb/tb_iter_normalize.sv
// Directed bench for iter_normalize at default parameters; expectations track NORM_ROUND_EN.
module tb_iter_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [69:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_mant;
  logic [7:0]  out_exp_adj;
  logic        out_zero;
  logic        out_inexact;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iter_normalize dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp_adj(out_exp_adj),
    .out_zero   (out_zero),
    .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Present one word, measure latency to out_valid and check the result fields.
  task automatic run_word(input string tag, input logic [69:0] d, input int lat_exp,
                          input logic [22:0] m_exp, input logic [7:0] e_exp,
                          input logic z_exp, input logic i_exp, input logic do_hs);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"},     70'(lat),         70'(lat_exp));
    chk({tag, "_mant"},    70'(out_mant),    70'(m_exp));
    chk({tag, "_exp"},     70'(out_exp_adj), 70'(e_exp));
    chk({tag, "_zero"},    70'(out_zero),    70'(z_exp));
    chk({tag, "_inexact"}, 70'(out_inexact), 70'(i_exp));
    chk({tag, "_rdy_busy"}, 70'(in_ready),   70'(0));
    if (do_hs) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_vld_clr"}, 70'(out_valid), 70'(0));
      chk({tag, "_rdy_ret"}, 70'(in_ready),  70'(1));
    end
  endtask

  logic [69:0] vec_a;
  logic [69:0] vec_ones;
  logic [22:0] mant_a;
  logic [22:0] mant_ones;
  logic [7:0]  exp_ones;
  logic        seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    vec_a     = {24'b000000000000000000010001, 23'b10101101011110000011111, 3'b111, 20'b0};
    vec_ones  = {25'h1FFFFFF, 45'b0};
`ifdef NORM_ROUND_EN
    mant_a    = 23'h0D6BC2;
    mant_ones = 23'h000000;
    exp_ones  = 8'h18;
`else
    mant_a    = 23'h0D6BC1;
    mant_ones = 23'h7FFFFF;
    exp_ones  = 8'h17;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   70'(in_ready),    70'(1));
    chk("rst_valid",   70'(out_valid),   70'(0));
    chk("rst_mant",    70'(out_mant),    70'(0));
    chk("rst_exp",     70'(out_exp_adj), 70'(0));
    chk("rst_zero",    70'(out_zero),    70'(0));
    chk("rst_inexact", 70'(out_inexact), 70'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_word("l19",  vec_a,                  6,  mant_a,   8'h04, 1'b0, 1'b1, 1'b1);
    run_word("msb",  70'h1 << 69,            2,  23'h0,    8'h17, 1'b0, 1'b0, 1'b1);
    run_word("zero", 70'h0,                  1,  23'h0,    8'h00, 1'b1, 1'b0, 1'b1);
    run_word("one",  70'h1,                  19, 23'h0,    8'hD2, 1'b0, 1'b0, 1'b1);
    run_word("ones", vec_ones,               2,  mant_ones, exp_ones, 1'b0, 1'b1, 1'b1);

    // Backpressure: hold DONE while offering a zero word that must be ignored.
    run_word("bp", 70'h1 << 66, 2, 23'h0, 8'h14, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = '0;
      @(posedge clk);
      #1;
      chk("bp_valid", 70'(out_valid),   70'(1));
      chk("bp_ready", 70'(in_ready),    70'(0));
      chk("bp_exp",   70'(out_exp_adj), 70'(8'h14));
      chk("bp_zero",  70'(out_zero),    70'(0));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_vld_clr", 70'(out_valid),   70'(0));
    chk("bp_rdy_ret", 70'(in_ready),    70'(1));
    chk("bp_hold",    70'(out_exp_adj), 70'(8'h14));
    chk("bp_nocap",   70'(out_zero),    70'(0));

    // Reset mid-SHIFT aborts the word.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 70'h1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ready",   70'(in_ready),    70'(1));
    chk("abort_valid",   70'(out_valid),   70'(0));
    chk("abort_mant",    70'(out_mant),    70'(0));
    chk("abort_exp",     70'(out_exp_adj), 70'(0));
    chk("abort_zero",    70'(out_zero),    70'(0));
    chk("abort_inexact", 70'(out_inexact), 70'(0));
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_emit", 70'(seen), 70'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
